// File: rtl/regfile_pkg.sv
// Shared defaults and write-FSM state encoding for the register-file access arbiter.
package regfile_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned AW_DEF      = 3;
  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned TIMEOUT_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(start) + k) % N);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares a 2-read/1-write register file between NREQ requesters: serialised writes
// through a small FSM with timeout, round-robin dual-port reads with write-hazard hold-off.
module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    wr_valid,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    wr_ack,
  output logic [NREQ-1:0]    wr_done,
  output logic               wr_err,
  input  logic [NREQ-1:0]    rd_valid,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]    rd_ack,
  output logic [NREQ-1:0]    rd_data_valid,
  output logic [NREQ*DW-1:0] rd_data,
  output logic               rf_rd_en1,
  output logic               rf_rd_en2,
  output logic [AW-1:0]      rf_rd_addr1,
  output logic [AW-1:0]      rf_rd_addr2,
  output logic               rf_wr_en,
  output logic [AW-1:0]      rf_wr_addr,
  output logic [DW-1:0]      rf_wr_data,
  input  logic [DW-1:0]      rf_rd_out1,
  input  logic [DW-1:0]      rf_rd_out2,
  input  logic               rf_wr_success
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (32'(v) == NREQ - 1) ? '0 : v + IW'(1);
  endfunction

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] wr_done_q, wr_done_d;
  logic            wr_err_q, wr_err_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            rv1_q, rv1_d, rv2_q, rv2_d;
  logic [IW-1:0]   ro1_q, ro1_d, ro2_q, ro2_d;

  logic [NREQ-1:0] w_oh, r1_oh, r2_oh, rd_elig;
  logic [IW-1:0]   w_idx, r1_idx, r2_idx;
  logic            w_found, r1_found, r2_found;

  rr_pick #(.N(NREQ), .IW(IW)) u_wr_pick (
    .req(wr_valid), .start(wr_ptr_q), .onehot(w_oh), .idx(w_idx), .found(w_found)
  );

  // Port 2 sees port 1's winner masked, so it yields the second eligible requester.
  rr_pick #(.N(NREQ), .IW(IW)) u_rd_pick1 (
    .req(rd_elig), .start(rd_ptr_q), .onehot(r1_oh), .idx(r1_idx), .found(r1_found)
  );
  rr_pick #(.N(NREQ), .IW(IW)) u_rd_pick2 (
    .req(rd_elig & ~r1_oh), .start(rd_ptr_q), .onehot(r2_oh), .idx(r2_idx), .found(r2_found)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    owner_d   = owner_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    wr_done_d = '0;
    wr_err_d  = 1'b0;
    wr_ack    = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          wr_ack   = w_oh;
          owner_d  = w_idx;
          waddr_d  = wr_addr[w_idx*AW +: AW];
          wdata_d  = wr_data[w_idx*DW +: DW];
          wr_ptr_d = inc_wrap(w_idx);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Success is checked first so it wins over a coincident timeout.
        if (rf_wr_success) begin
          wr_done_d[owner_q] = 1'b1;
          state_d            = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          wr_done_d[owner_q] = 1'b1;
          wr_err_d           = 1'b1;
          state_d            = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) wr_ack = '0;
  end

  always_comb begin
    rd_elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rd_elig[i] = rd_valid[i] &&
                   !((state_q != ST_IDLE) && (rd_addr[i*AW +: AW] == waddr_q));
    end
    rd_ack      = rst ? '0 : (r1_oh | r2_oh);
    rf_rd_en1   = r1_found && !rst;
    rf_rd_en2   = r2_found && !rst;
    rf_rd_addr1 = rf_rd_en1 ? rd_addr[r1_idx*AW +: AW] : '0;
    rf_rd_addr2 = rf_rd_en2 ? rd_addr[r2_idx*AW +: AW] : '0;
    rv1_d       = r1_found;
    rv2_d       = r2_found;
    ro1_d       = r1_idx;
    ro2_d       = r2_idx;
    if (r2_found)      rd_ptr_d = inc_wrap(r2_idx);
    else if (r1_found) rd_ptr_d = inc_wrap(r1_idx);
    else               rd_ptr_d = rd_ptr_q;
  end

  always_comb begin
    rd_data       = '0;
    rd_data_valid = '0;
    if (rv1_q) begin
      rd_data[ro1_q*DW +: DW] = rf_rd_out1;
      rd_data_valid[ro1_q]    = 1'b1;
    end
    if (rv2_q) begin
      rd_data[ro2_q*DW +: DW] = rf_rd_out2;
      rd_data_valid[ro2_q]    = 1'b1;
    end
  end

  assign rf_wr_en   = (state_q == ST_ISSUE);
  assign rf_wr_addr = waddr_q;
  assign rf_wr_data = wdata_q;
  assign wr_done    = wr_done_q;
  assign wr_err     = wr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      owner_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      wr_done_q <= '0;
      wr_err_q  <= 1'b0;
      rd_ptr_q  <= '0;
      rv1_q     <= 1'b0;
      rv2_q     <= 1'b0;
      ro1_q     <= '0;
      ro2_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      owner_q   <= owner_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
      wr_err_q  <= wr_err_d;
      rd_ptr_q  <= rd_ptr_d;
      rv1_q     <= rv1_d;
      rv2_q     <= rv2_d;
      ro1_q     <= ro1_d;
      ro2_q     <= ro2_d;
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a behavioural 8x8 register file.
module tb_regfile_access_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   wr_valid, wr_ack, wr_done;
  logic [NREQ*AW-1:0] wr_addr, rd_addr;
  logic [NREQ*DW-1:0] wr_data, rd_data;
  logic              wr_err;
  logic [NREQ-1:0]   rd_valid, rd_ack, rd_data_valid;
  logic              rf_rd_en1, rf_rd_en2, rf_wr_en, rf_wr_success;
  logic [AW-1:0]     rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [DW-1:0]     rf_wr_data, rf_rd_out1, rf_rd_out2;
  logic              succ_en;
  logic [DW-1:0]     rf_mem [8];

  int n_cmp = 0;
  int n_err = 0;

  regfile_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_done(wr_done), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_out1(rf_rd_out1), .rf_rd_out2(rf_rd_out2),
    .rf_wr_success(rf_wr_success)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, success reported the cycle after rf_wr_en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h10 + 8'(i);
      rf_rd_out1    <= '0;
      rf_rd_out2    <= '0;
      rf_wr_success <= 1'b0;
    end else begin
      if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
      rf_rd_out1    <= rf_mem[rf_rd_addr1];
      rf_rd_out2    <= rf_mem[rf_rd_addr2];
      rf_wr_success <= rf_wr_en & succ_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; succ_en = 1'b1;
    wr_valid = '0; wr_addr = '0; wr_data = '0;
    rd_valid = '0; rd_addr = '0;
    nxt(); nxt();
    #1;
    check("rst_wr_done", 32'(wr_done), 32'h0);
    check("rst_rd_dv", 32'(rd_data_valid), 32'h0);
    check("rst_rf_wr_en", 32'(rf_wr_en), 32'h0);
    rst = 1'b0;

    // single write then read
    nxt(); set_wr(1, 3'd1, 8'h03); wr_valid = 4'b0010; #1;
    check("t1_wr_ack", 32'(wr_ack), 32'h2);
    nxt(); wr_valid = '0; #1;
    check("t1_rf_wr_en", 32'(rf_wr_en), 32'h1);
    check("t1_rf_wr_addr", 32'(rf_wr_addr), 32'h1);
    check("t1_rf_wr_data", 32'(rf_wr_data), 32'h03);
    nxt(); #1;
    check("t1_wr_en_once", 32'(rf_wr_en), 32'h0);
    check("t1_no_done_yet", 32'(wr_done), 32'h0);
    nxt(); #1;
    check("t1_wr_done", 32'(wr_done), 32'h2);
    check("t1_wr_err", 32'(wr_err), 32'h0);
    nxt(); set_rd(0, 3'd1); rd_valid = 4'b0001; #1;
    check("t1_done_pulse", 32'(wr_done), 32'h0);
    check("t1_rd_ack", 32'(rd_ack), 32'h1);
    check("t1_rf_rd_addr1", 32'(rf_rd_addr1), 32'h1);
    nxt(); rd_valid = '0; #1;
    check("t1_rd_dv", 32'(rd_data_valid), 32'h1);
    check("t1_rd_data", 32'(rd_data), 32'h03);

    // round-robin writes from a fresh pointer
    do_reset();
    for (int i = 0; i < NREQ; i++) set_wr(i, 3'(4 + i), 8'hA0 + 8'(i));
    wr_valid = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      #1;
      check("rr_ack", 32'(wr_ack), 32'h1 << k);
      nxt(); wr_valid[k] = 1'b0;
      nxt(); nxt(); #1;
      check("rr_done", 32'(wr_done), 32'h1 << k);
      check("rr_err", 32'(wr_err), 32'h0);
      nxt();
    end
    wr_valid = 4'b1001; #1;
    check("rr_wrap_ack", 32'(wr_ack), 32'h1);
    nxt(); wr_valid = '0;
    nxt(); nxt(); #1;
    check("rr_wrap_done", 32'(wr_done), 32'h1);
    nxt();

    // dual read
    set_rd(0, 3'd1); set_rd(2, 3'd2); set_rd(3, 3'd5); rd_valid = 4'b1101; #1;
    check("dr_ack0", 32'(rd_ack), 32'h5);
    check("dr_addr1", 32'(rf_rd_addr1), 32'h1);
    check("dr_addr2", 32'(rf_rd_addr2), 32'h2);
    check("dr_en2", 32'(rf_rd_en2), 32'h1);
    nxt(); rd_valid = 4'b1000; #1;
    check("dr_ack1", 32'(rd_ack), 32'h8);
    check("dr_addr1b", 32'(rf_rd_addr1), 32'h5);
    check("dr_en2b", 32'(rf_rd_en2), 32'h0);
    check("dr_dv0", 32'(rd_data_valid), 32'h5);
    check("dr_data0", 32'(rd_data), 32'h00120011);
    nxt(); rd_valid = '0; #1;
    check("dr_dv1", 32'(rd_data_valid), 32'h8);
    check("dr_data1", 32'(rd_data), 32'hA1000000);

    // write hazard
    nxt(); set_wr(1, 3'd2, 8'h05); wr_valid = 4'b0010; #1;
    check("hz_wr_ack", 32'(wr_ack), 32'h2);
    nxt(); wr_valid = '0; set_rd(0, 3'd2); set_rd(3, 3'd4); rd_valid = 4'b1001; #1;
    check("hz_ack_issue", 32'(rd_ack), 32'h8);
    check("hz_addr_free", 32'(rf_rd_addr1), 32'h4);
    nxt(); rd_valid = 4'b0001; #1;
    check("hz_ack_wait", 32'(rd_ack), 32'h0);
    check("hz_free_dv", 32'(rd_data_valid), 32'h8);
    check("hz_free_data", 32'(rd_data), 32'hA0000000);
    nxt(); #1;
    check("hz_ack_done", 32'(rd_ack), 32'h0);
    check("hz_wr_done", 32'(wr_done), 32'h2);
    nxt(); #1;
    check("hz_ack_idle", 32'(rd_ack), 32'h1);
    nxt(); rd_valid = '0; #1;
    check("hz_dv", 32'(rd_data_valid), 32'h1);
    check("hz_data", 32'(rd_data), 32'h05);

    // timeout
    nxt(); succ_en = 1'b0; set_wr(2, 3'd3, 8'h77); wr_valid = 4'b0100; #1;
    check("to_ack", 32'(wr_ack), 32'h4);
    nxt(); wr_valid = '0;
    for (int c = 1; c <= TO + 2; c++) begin
      #1;
      check("to_early", 32'(wr_done), 32'h0);
      nxt();
    end
    #1;
    check("to_done", 32'(wr_done), 32'h4);
    check("to_err", 32'(wr_err), 32'h1);
    nxt(); set_wr(1, 3'd6, 8'h66); wr_valid = 4'b0010; #1;
    check("to_next_ack", 32'(wr_ack), 32'h2);

    // reset while waiting for success
    nxt(); wr_valid = '0;
    nxt(); nxt();
    for (int i = 0; i < NREQ; i++) set_rd(i, 3'(i));
    rd_valid = 4'b1111; wr_valid = 4'b1111; rst = 1'b1; #1;
    check("mr_wr_ack", 32'(wr_ack), 32'h0);
    check("mr_rd_ack", 32'(rd_ack), 32'h0);
    check("mr_rf_wr_en", 32'(rf_wr_en), 32'h0);
    check("mr_rd_en", 32'({rf_rd_en1, rf_rd_en2}), 32'h0);
    check("mr_wr_done", 32'(wr_done), 32'h0);
    check("mr_rd_dv", 32'(rd_data_valid), 32'h0);
    nxt(); #1;
    check("mr_wr_done2", 32'(wr_done), 32'h0);
    nxt(); rst = 1'b0; #1;
    check("mr_first_wr_ack", 32'(wr_ack), 32'h1);
    check("mr_first_rd_ack", 32'(rd_ack), 32'h3);
    check("mr_no_done", 32'(wr_done), 32'h0);
    nxt(); wr_valid = '0; rd_valid = '0;
    nxt(); nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
